// File: rtl/seq_nbyonemux.sv
// rtl/seq_nbyonemux.sv - registered N-to-1 mux with handshaked select and break-before-make dead time
// A channel change blanks the output for GAP+1 cycles so no mixed word ever reaches downstream logic.
module seq_nbyonemux #(
  parameter int WIDTH   = 8,
  parameter int NCH     = 4,
  parameter int SELW    = $clog2(NCH),
  parameter int GAP     = 2,
  parameter int RST_SEL = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*WIDTH-1:0]   in,
  input  logic [SELW-1:0]        sel_req,
  input  logic                   sel_vld,
  output logic                   sel_rdy,
  output logic [WIDTH-1:0]       y,
  output logic                   y_vld,
  output logic [SELW-1:0]        cur_sel,
  output logic                   err
);

  localparam int CNTW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic {S_RUN, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   cur_sel_q, cur_sel_d;
  logic [SELW-1:0]   pend_q, pend_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              y_vld_q, y_vld_d;
  logic              err_q, err_d;

  logic [WIDTH-1:0]  ch [NCH];
  logic              req_oob;

  for (genvar c = 0; c < NCH; c++) begin : g_unpack
    assign ch[c] = in[c*WIDTH +: WIDTH];
  end

  // Zero-extend by one bit so NCH itself is representable when NCH is a power of two.
  assign req_oob = ({1'b0, sel_req} >= (SELW+1)'(NCH));

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    y_vld_d   = y_vld_q;
    err_d     = 1'b0;
    case (state_q)
      S_RUN: begin
        y_d     = ch[cur_sel_q];
        y_vld_d = 1'b1;
        if (sel_vld) begin
          if (req_oob) begin
            err_d = 1'b1;
          end else if (sel_req != cur_sel_q) begin
            pend_d  = sel_req;
            cnt_d   = CNTW'(GAP - 1);
            state_d = S_GAP;
            y_d     = '0;
            y_vld_d = 1'b0;
          end
        end
      end
      S_GAP: begin
        y_d     = '0;
        y_vld_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cur_sel_d = pend_q;
          state_d   = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
        y_d     = '0;
        y_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      cur_sel_q <= SELW'(RST_SEL);
      pend_q    <= SELW'(RST_SEL);
      cnt_q     <= '0;
      y_q       <= '0;
      y_vld_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_vld_q   <= y_vld_d;
      err_q     <= err_d;
    end
  end

  assign sel_rdy = (state_q == S_RUN);
  assign y       = y_q;
  assign y_vld   = y_vld_q;
  assign cur_sel = cur_sel_q;
  assign err     = err_q;

endmodule

// File: tb/tb_seq_nbyonemux.sv
// tb/tb_seq_nbyonemux.sv - scoreboard bench for seq_nbyonemux
// Two instances share stimulus: A (NCH=4, GAP=2, RST_SEL=0) and B (NCH=3, GAP=3, RST_SEL=1).
module tb_seq_nbyonemux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_a;
  logic [23:0] in_b;
  logic [1:0]  sel_req;
  logic        sel_vld;

  logic        a_rdy, a_vld, a_err;
  logic [7:0]  a_y;
  logic [1:0]  a_cur;
  logic        b_rdy, b_vld, b_err;
  logic [7:0]  b_y;
  logic [1:0]  b_cur;

  assign in_b = in_a[23:0];

  always #5 clk = ~clk;

  seq_nbyonemux #(.WIDTH(8), .NCH(4), .GAP(2), .RST_SEL(0)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .sel_req(sel_req), .sel_vld(sel_vld),
    .sel_rdy(a_rdy), .y(a_y), .y_vld(a_vld), .cur_sel(a_cur), .err(a_err)
  );

  seq_nbyonemux #(.WIDTH(8), .NCH(3), .GAP(3), .RST_SEL(1)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .sel_req(sel_req), .sel_vld(sel_vld),
    .sel_rdy(b_rdy), .y(b_y), .y_vld(b_vld), .cur_sel(b_cur), .err(b_err)
  );

  typedef struct { int cur; int pend; int gap_left; } mstate_t;
  typedef struct { int y; int vld; int rdy; int cur; int err; } exp_t;

  mstate_t ms_a, ms_b;
  exp_t    q_a[$], q_b[$];
  int      n_chk  = 0;
  int      n_fail = 0;

  function automatic exp_t rst_exp(input int rsel);
    exp_t e;
    e.y = 0; e.vld = 0; e.rdy = 1; e.cur = rsel; e.err = 0;
    return e;
  endfunction

  function automatic mstate_t rst_state(input int rsel);
    mstate_t s;
    s.cur = rsel; s.pend = rsel; s.gap_left = 0;
    return s;
  endfunction

  // gap_left counts the blank edges still owed; the new channel takes over when it hits zero.
  function automatic mstate_t model_step(input mstate_t s, input int nch, input int gap,
                                         input logic [31:0] bus, input logic v, input int req,
                                         output exp_t e);
    mstate_t n = s;
    int word = int'((bus >> (8 * s.cur)) & 32'hFF);
    e.y = 0; e.vld = 0; e.err = 0;
    if (s.gap_left > 0) begin
      n.gap_left = s.gap_left - 1;
      if (n.gap_left == 0) n.cur = s.pend;
    end else if (v && req >= nch) begin
      e.err = 1; e.y = word; e.vld = 1;
    end else if (v && req != s.cur) begin
      n.pend = req; n.gap_left = gap;
    end else begin
      e.y = word; e.vld = 1;
    end
    e.rdy = (n.gap_left == 0) ? 1 : 0;
    e.cur = n.cur;
    return n;
  endfunction

  always @(posedge clk) begin
    exp_t ea, eb;
    if (rst) begin
      ms_a = rst_state(0);
      ms_b = rst_state(1);
      ea = rst_exp(0);
      eb = rst_exp(1);
    end else begin
      ms_a = model_step(ms_a, 4, 2, in_a, sel_vld, int'(sel_req), ea);
      ms_b = model_step(ms_b, 3, 3, {8'h00, in_b}, sel_vld, int'(sel_req), eb);
    end
    q_a.push_back(ea);
    q_b.push_back(eb);
  end

  task automatic cmp(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string tag, input exp_t e, input logic [7:0] y,
                            input logic vld, input logic rdy, input logic [1:0] cur, input logic er);
    cmp({tag, ".y"},       32'(y),   e.y);
    cmp({tag, ".y_vld"},   32'(vld), e.vld);
    cmp({tag, ".sel_rdy"}, 32'(rdy), e.rdy);
    cmp({tag, ".cur_sel"}, 32'(cur), e.cur);
    cmp({tag, ".err"},     32'(er),  e.err);
  endtask

  // Monitor: one expected tuple per edge; reset asserted mid-cycle overrides it.
  always @(negedge clk) begin
    exp_t ea, eb;
    if (q_a.size() == 0 || q_b.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
    end else begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      if (rst) begin
        ea = rst_exp(0);
        eb = rst_exp(1);
      end
      check_inst("A", ea, a_y, a_vld, a_rdy, a_cur, a_err);
      check_inst("B", eb, b_y, b_vld, b_rdy, b_cur, b_err);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    sel_vld = 1'b0;
    sel_req = 2'd0;
    in_a    = 32'h44332211;
    rst     = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    // switch 0 -> 2
    sel_vld = 1'b1; sel_req = 2'd2; cyc(1);
    sel_vld = 1'b0; cyc(6);
    // switch to 1, then same-channel request held
    sel_vld = 1'b1; sel_req = 2'd1; cyc(1);
    sel_vld = 1'b0; cyc(6);
    sel_vld = 1'b1; sel_req = 2'd1; cyc(3);
    sel_vld = 1'b0; cyc(2);
    // back to 0, then 0 -> 1 with a request for 3 held through the gap
    sel_vld = 1'b1; sel_req = 2'd0; cyc(1);
    sel_vld = 1'b0; cyc(6);
    sel_vld = 1'b1; sel_req = 2'd1; cyc(1);
    sel_req = 2'd3; cyc(10);
    sel_vld = 1'b0; cyc(3);
    // back to 0, then reset one cycle into a 0 -> 2 switch
    sel_vld = 1'b1; sel_req = 2'd0; cyc(1);
    sel_vld = 1'b0; cyc(6);
    sel_vld = 1'b1; sel_req = 2'd2; cyc(1);
    sel_vld = 1'b0; cyc(1);
    rst = 1'b1; cyc(2);
    rst = 1'b0; cyc(5);
    // randomized traffic with changing data and occasional resets
    for (int i = 0; i < 3000; i++) begin
      in_a    = $urandom;
      sel_vld = ($urandom_range(0, 3) == 0);
      sel_req = 2'($urandom_range(0, 3));
      rst     = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    rst = 1'b0;
    sel_vld = 1'b0;
    cyc(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule

// File: doc/seq_nbyonemux.md
# seq_nbyonemux

Parametrised, registered N-to-1 multiplexer with a handshaked channel-select port and a break-before-make switch sequence. It replaces the combinational CMOS 2:1 mux wherever a selected data lane feeds clocked logic. A channel change never produces a mixed or glitched word: the output is forced to zero and flagged invalid for a programmable dead time before the new channel is driven.

## Interface
- `WIDTH`, default 8: data width per channel.
- `NCH`, default 4: number of input channels, minimum 2.
- `SELW`, default `$clog2(NCH)`: select width.
- `GAP`, default 2: dead cycles inserted on a channel change, minimum 1.
- `RST_SEL`, default 0: channel selected out of reset, must be less than `NCH`.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in`, in, `NCH*WIDTH`: channel c occupies bits `[c*WIDTH +: WIDTH]`.
- `sel_req`, in, `SELW`: requested channel.
- `sel_vld`, in, 1: `sel_req` is valid.
- `sel_rdy`, out, 1: block can accept a select request.
- `y`, out, `WIDTH`: registered output.
- `y_vld`, out, 1: `y` carries data from `cur_sel`.
- `cur_sel`, out, `SELW`: channel currently driven.
- `err`, out, 1: one-cycle pulse when an out-of-range request is rejected.

## Operation
- States are `RUN` and `GAP`.
- `sel_rdy` is combinational: 1 in `RUN`, 0 in `GAP`. A request is accepted on an edge where `sel_vld && sel_rdy`.
- **RUN:**
  - Every edge: `y <= in[cur_sel]`, `y_vld <= 1`.
- **Accept rules in RUN:**
  - `sel_req == cur_sel`: no-op. The state stays `RUN`, there is no gap, and `y` keeps streaming.
  - `sel_req >= NCH`: rejected. `err <= 1` for one cycle, the state stays `RUN`, and `cur_sel` and streaming are unchanged.
  - Otherwise:
    - `pend <= sel_req`, `cnt <= GAP-1`, state goes to `GAP`.
    - `y <= 0`, `y_vld <= 0`.
- **GAP:**
  - `y` holds 0 and `y_vld` holds 0. `sel_vld` is ignored and requests are not queued.
  - If `cnt != 0`: `cnt <= cnt-1`.
  - If `cnt == 0`: `cur_sel <= pend`, state goes to `RUN`, `y` and `y_vld` stay 0 for this edge.
- **Reset (asynchronous, any state, including mid-GAP):**
  - State `RUN`, `cur_sel = RST_SEL`, `y = 0`, `y_vld = 0`, `err = 0`, `cnt = 0`, `pend = RST_SEL`.
  - A pending switch is discarded.
- `err` is 0 on every edge except the one following a rejected request.
- Data on `in` is sampled only for `cur_sel`. Other channels may change freely.

## Timing
- Data latency is 1 cycle: `in[cur_sel]` sampled at edge t appears on `y` after edge t.
- After reset release, the first edge gives `y = in[RST_SEL]` with `y_vld = 1`.
- A switch accepted at edge k:
  - `y_vld` is low after edges k through k+GAP (GAP+1 cycles).
  - `cur_sel` changes at edge k+GAP.
  - The first new-channel data is valid after edge k+GAP+1.
  - `sel_rdy` is low from after edge k until after edge k+GAP.
- Back-to-back requests: a request held high with `sel_rdy` low is accepted on the first edge after return to `RUN`.
- An `err` pulse is high for exactly one cycle after edge k and does not affect `sel_rdy`.

## Test plan
- **Reset and streaming:**
  - Stimulus: `rst` pulse, `in = {8'h44, 8'h33, 8'h22, 8'h11}`.
  - Response: during reset `y = 0`, `y_vld = 0`. After the first edge following release, `y = 8'h11`, `y_vld = 1`, `cur_sel = 0`, `sel_rdy = 1`.
- **Switch 0 to 2 with GAP = 2:**
  - Stimulus: request accepted at edge k.
  - Response: `y = 0`, `y_vld = 0` for 3 cycles. `cur_sel = 2` after edge k+2. `y = 8'h33`, `y_vld = 1` after edge k+3. `sel_rdy` low for 2 cycles.
- **Same-channel request:**
  - Stimulus: `sel_req = cur_sel = 1`.
  - Response: `y_vld` stays 1, no zero word, `cur_sel` stays 1, `err = 0`.
- **Out-of-range request with `NCH = 3`:**
  - Stimulus: `sel_req = 3`.
  - Response: `err` high for one cycle, `cur_sel` unchanged, streaming uninterrupted.
- **Request during GAP:**
  - Stimulus: `sel_vld` held with `sel_req = 3` while a 0→1 switch is in progress.
  - Response: first switch completes to 1. The second request is accepted on the first `RUN` edge, then a second full gap follows and the block ends on channel 3.
- **Reset mid-GAP:**
  - Stimulus: assert `rst` one cycle into a 0→2 switch.
  - Response: `cur_sel = 0` immediately, state `RUN`. After release, `y = in[0]` and channel 2 is never driven.
